// File: rtl/address_gen_unit.sv
// Effective-address generator: a lane-loadable address register with inc/dec and
// a signed/unsigned index add, plus an optional one-cycle page-crossing fix-up.
module address_gen_unit #(
    parameter int              DATA_W       = 8,
    parameter int              ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'hFFFC,
    parameter bit              PAGE_FIXUP   = 1'b1,
    localparam int             LANES        = ADDR_W / DATA_W,
    localparam int             SW           = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_wr,
    input  logic [SW-1:0]     i_byte_sel,
    input  logic [SW-1:0]     i_rd_sel,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_add_index,
    input  logic              i_index_signed,
    input  logic              i_wrap_page,
    input  logic [DATA_W-1:0] i_index,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_page_cross,
    output logic              o_state
);
    localparam int UW = ADDR_W - DATA_W;

    typedef enum logic {IDLE = 1'b0, FIXUP = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic                r_page_cross, w_page_cross_next;
    logic                r_fix_inc, w_fix_inc_next;

    logic [DATA_W-1:0]   w_low;
    logic [UW-1:0]       w_upper;
    logic [DATA_W:0]     w_sum;
    logic                w_carry;
    logic                w_neg;
    logic                w_cross;
    logic [UW-1:0]       w_upper_adj;
    logic [UW-1:0]       w_upper_fix;

    assign w_low   = r_addr[DATA_W-1:0];
    assign w_upper = r_addr[ADDR_W-1:DATA_W];
    assign w_sum   = {1'b0, w_low} + {1'b0, i_index};
    assign w_carry = w_sum[DATA_W];
    assign w_neg   = i_index_signed & i_index[DATA_W-1];
    // Carry out and the sign-extension borrow cancel each other; only one alone moves the page.
    assign w_cross     = w_carry ^ w_neg;
    assign w_upper_adj = w_carry ? (w_upper + 1'b1) : (w_upper - 1'b1);
    assign w_upper_fix = r_fix_inc ? (w_upper + 1'b1) : (w_upper - 1'b1);

    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_page_cross_next = 1'b0;
        w_fix_inc_next    = r_fix_inc;
        if (r_state == FIXUP) begin
            w_addr_next[ADDR_W-1:DATA_W] = w_upper_fix;
            w_state_next                 = IDLE;
        end else if (i_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (int'(i_byte_sel) == l) begin
                    w_addr_next[l*DATA_W +: DATA_W] = i_data_in;
                end
            end
        end else if (i_inc) begin
            w_addr_next = r_addr + 1'b1;
        end else if (i_dec) begin
            w_addr_next = r_addr - 1'b1;
        end else if (i_add_index) begin
            w_addr_next[DATA_W-1:0] = w_sum[DATA_W-1:0];
            if (!i_wrap_page && w_cross) begin
                w_page_cross_next = 1'b1;
                if (PAGE_FIXUP) begin
                    w_state_next   = FIXUP;
                    w_fix_inc_next = w_carry;
                end else begin
                    w_addr_next[ADDR_W-1:DATA_W] = w_upper_adj;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= RESET_VECTOR;
            r_page_cross <= 1'b0;
            r_fix_inc    <= 1'b0;
        end else if (i_clk_en) begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_page_cross <= w_page_cross_next;
            r_fix_inc    <= w_fix_inc_next;
        end
    end

    always_comb begin
        o_data_out = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(i_rd_sel) == l) begin
                o_data_out = r_addr[l*DATA_W +: DATA_W];
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_busy       = (r_state == FIXUP);
    assign o_page_cross = r_page_cross;
    assign o_state      = r_state;
endmodule
